// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared limits and saturating-increment helper for the sequence detector
package seq_det_pkg;
  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 32;
  localparam int CNT_W_MAX = 32;
  // Returns {overflow, next}; an all-ones value of the given width holds and flags overflow.
  function automatic logic [CNT_W_MAX:0] sat_inc(input logic [CNT_W_MAX-1:0] value, input int width);
    logic [CNT_W_MAX-1:0] ones;
    ones = CNT_W_MAX'((33'd1 << width) - 33'd1);
    return (value == ones) ? {1'b1, value} : {1'b0, value + 1'b1};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with sticky overflow and clear that still counts a concurrent event
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic [CNT_W_MAX:0] nxt;
  assign nxt = sat_inc(CNT_W_MAX'(cnt), CNT_W);
  // Clear wins over saturation state, but an increment in the same cycle lands after the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= CNT_W'(inc);
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= CNT_W'(nxt);
      ovf <= ovf | nxt[CNT_W_MAX];
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector with enable, overlap control and match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int            LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b001,
  parameter bit            OVERLAP = 1'b1,
  parameter bit            REG_OUT = 1'b0,
  parameter int            CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inp,
  input  logic             clr_cnt,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf
);
  localparam int FW = $clog2(LEN);
  if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
    $error("seq_detector_param: LEN out of range");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W out of range");
  end
  logic [LEN-2:0] hist;
  logic [FW-1:0]  fill;
  logic [LEN-1:0] window;
  logic           hit;
  logic           det_q;
  assign window = {hist, inp};
  assign hit = ~reset & en & (fill == FW'(LEN - 1)) & (window == PATTERN);
  assign det = REG_OUT ? det_q : hit;
  // History shifts on accepted bits; a non-overlapping match empties it so the next match starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist  <= '0;
      fill  <= '0;
      det_q <= 1'b0;
    end else begin
      det_q <= hit;
      if (en) begin
        if (hit && !OVERLAP) begin
          fill <= '0;
        end else begin
          hist <= window[LEN-2:0];
          fill <= (fill == FW'(LEN - 1)) ? fill : fill + 1'b1;
        end
      end
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (hit),
    .clr  (clr_cnt),
    .cnt  (match_cnt),
    .ovf  (cnt_ovf)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: table-driven check of five detector configurations on a shared stimulus bus
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic inp = 1'b0;
  logic clr_cnt = 1'b0;
  always #5 clk = ~clk;

  logic       det_a [5];
  logic       ovf_a [5];
  int         cnt_a [5];
  logic [7:0] mc0, mc1, mc2, mc3;
  logic [1:0] mc4;

  seq_detector_param u0 (.clk(clk), .reset(reset), .en(en), .inp(inp), .clr_cnt(clr_cnt),
    .det(det_a[0]), .match_cnt(mc0), .cnt_ovf(ovf_a[0]));
  seq_detector_param #(.LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b1)) u1 (.clk(clk), .reset(reset),
    .en(en), .inp(inp), .clr_cnt(clr_cnt), .det(det_a[1]), .match_cnt(mc1), .cnt_ovf(ovf_a[1]));
  seq_detector_param #(.LEN(4), .PATTERN(4'b0101), .OVERLAP(1'b0)) u2 (.clk(clk), .reset(reset),
    .en(en), .inp(inp), .clr_cnt(clr_cnt), .det(det_a[2]), .match_cnt(mc2), .cnt_ovf(ovf_a[2]));
  seq_detector_param #(.REG_OUT(1'b1)) u3 (.clk(clk), .reset(reset), .en(en), .inp(inp),
    .clr_cnt(clr_cnt), .det(det_a[3]), .match_cnt(mc3), .cnt_ovf(ovf_a[3]));
  seq_detector_param #(.CNT_W(2)) u4 (.clk(clk), .reset(reset), .en(en), .inp(inp),
    .clr_cnt(clr_cnt), .det(det_a[4]), .match_cnt(mc4), .cnt_ovf(ovf_a[4]));

  assign cnt_a[0] = int'(mc0);
  assign cnt_a[1] = int'(mc1);
  assign cnt_a[2] = int'(mc2);
  assign cnt_a[3] = int'(mc3);
  assign cnt_a[4] = int'(mc4);

  typedef struct {
    logic r, e, i, c;
    int   u;
    logic d;
    int   n;
    logic o;
  } vec_t;
  vec_t v[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic a(input logic r, e, i, c, input int u, input logic d, input int n, input logic o);
    vec_t t;
    t.r = r; t.e = e; t.i = i; t.c = c; t.u = u; t.d = d; t.n = n; t.o = o;
    v.push_back(t);
  endtask

  initial begin
    a(1,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0, 0,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,1,0,0,1, 0,0);
    a(0,1,0,0,0,0, 1,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,1,0,0,1, 1,0);
    a(0,1,1,0,0,0, 2,0);
    a(0,0,0,0,0,0, 2,0);
    a(1,1,0,0,1,0,-1,0);
    a(0,1,0,0,1,0, 0,0);
    a(0,1,1,0,1,0,-1,0);
    a(0,1,0,0,1,0,-1,0);
    a(0,1,1,0,1,1,-1,0);
    a(0,1,0,0,1,0, 1,0);
    a(0,1,1,0,1,1,-1,0);
    a(0,0,0,0,1,0, 2,0);
    a(1,1,0,0,2,0,-1,0);
    a(0,1,0,0,2,0, 0,0);
    a(0,1,1,0,2,0,-1,0);
    a(0,1,0,0,2,0,-1,0);
    a(0,1,1,0,2,1,-1,0);
    a(0,1,0,0,2,0, 1,0);
    a(0,1,1,0,2,0,-1,0);
    a(0,0,0,0,2,0, 1,0);
    a(1,1,0,0,3,0,-1,0);
    a(0,1,0,0,3,0,-1,0);
    a(0,1,0,0,3,0,-1,0);
    a(0,1,1,0,3,0,-1,0);
    a(0,0,0,0,3,1, 1,0);
    a(0,0,0,0,3,0,-1,0);
    a(1,1,0,0,3,0,-1,0);
    a(0,1,0,0,3,0,-1,0);
    a(0,1,0,0,3,0,-1,0);
    a(1,1,1,0,3,0,-1,0);
    a(0,0,0,0,3,0, 0,0);
    a(1,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0, 0,0);
    a(0,0,1,0,0,0,-1,0);
    a(0,0,1,0,0,0,-1,0);
    a(0,0,1,0,0,0,-1,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,1,0,0,1, 0,0);
    a(0,0,0,0,0,0, 1,0);
    a(1,1,0,0,4,0,-1,0);
    a(0,1,0,0,4,0, 0,0);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,0,4,1, 0,0);
    a(0,1,0,0,4,0, 1,0);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,0,4,1, 1,0);
    a(0,1,0,0,4,0, 2,0);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,0,4,1, 2,0);
    a(0,1,0,0,4,0, 3,0);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,0,4,1, 3,0);
    a(0,1,0,0,4,0, 3,1);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,0,4,1, 3,1);
    a(0,1,0,0,4,0, 3,1);
    a(0,1,0,0,4,0,-1,0);
    a(0,1,1,1,4,1, 3,1);
    a(0,0,0,1,4,0, 1,0);
    a(0,0,0,0,4,0, 0,0);
    a(1,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0,-1,0);
    a(1,1,1,0,0,0,-1,0);
    a(0,1,1,0,0,0, 0,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,0,0,0,0,-1,0);
    a(0,1,1,0,0,1, 0,0);
    a(0,0,0,0,0,0, 1,0);
    for (int k = 0; k < v.size(); k++) begin
      @(negedge clk);
      reset = v[k].r;
      en = v[k].e;
      inp = v[k].i;
      clr_cnt = v[k].c;
      #1;
      n_vec++;
      if (det_a[v[k].u] !== v[k].d) begin
        n_bad++;
        $display("FAIL vec %0d det u%0d: got %b want %b", k, v[k].u, det_a[v[k].u], v[k].d);
      end
      if (v[k].n >= 0) begin
        if (cnt_a[v[k].u] !== v[k].n) begin
          n_bad++;
          $display("FAIL vec %0d match_cnt u%0d: got %0d want %0d", k, v[k].u, cnt_a[v[k].u], v[k].n);
        end
        if (ovf_a[v[k].u] !== v[k].o) begin
          n_bad++;
          $display("FAIL vec %0d cnt_ovf u%0d: got %b want %b", k, v[k].u, ovf_a[v[k].u], v[k].o);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
